battle_turn_ctrl: RTL and testbench

Sequential turn controller for one-on-one battles. Holds both Pokémon's HP registers and alternates player and enemy turns. On each hit it drives the attacker/defender operands into the combinational `calc_hp` stage and commits `calc_hp`'s `hp_out`/`poke_faint` back into the defender's HP register. It sits between the keyboard/game-state logic upstream and `calc_hp`, and feeds HP values and battle status to the sprite/HUD draw logic downstream.

---
 rtl/battle_pkg.sv | 31 +++
 rtl/delay_counter.sv | 40 ++++
 rtl/battle_turn_ctrl.sv | 156 +++++++++++++++
 tb/tb_battle_turn_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// -----------------------------------------------------------------------------
// battle_pkg
// Shared types and constants for the battle turn controller.
//   turn_state_t : controller states
//   LEAF..FIGHTING : 3-bit type codes understood by calc_hp
//   HP_W, STAT_W : HP and stat field widths
// -----------------------------------------------------------------------------
package battle_pkg;

   localparam int HP_W   = 6;
   localparam int STAT_W = 4;

   localparam logic [2:0] LEAF     = 3'd0;
   localparam logic [2:0] FIRE     = 3'd1;
   localparam logic [2:0] WATER    = 3'd2;
   localparam logic [2:0] THUNDER  = 3'd3;
   localparam logic [2:0] FLYING   = 3'd4;
   localparam logic [2:0] ROCK     = 3'd5;
   localparam logic [2:0] PSYCHIC  = 3'd6;
   localparam logic [2:0] FIGHTING = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_PLAYER_WAIT = 3'd1,
      ST_PLAYER_HIT  = 3'd2,
      ST_ENEMY_WAIT  = 3'd3,
      ST_ENEMY_HIT   = 3'd4,
      ST_DONE        = 3'd5
   } turn_state_t;

endpackage

// File: rtl/delay_counter.sv
// -----------------------------------------------------------------------------
// delay_counter
// Loadable down-counter with a zero flag; times the enemy's thinking delay.
//   clk, Reset   : clock, synchronous active-high reset (count -> 0)
//   load_i       : load load_val_i (wins over dec_i)
//   load_val_i   : value to load
//   dec_i        : decrement by one; holds at zero rather than wrapping
//   zero_o       : count is zero
// -----------------------------------------------------------------------------
module delay_counter #(
   parameter int W = 5
)(
   input  logic         clk,
   input  logic         Reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk) begin
      if (Reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/battle_turn_ctrl.sv
// -----------------------------------------------------------------------------
// battle_turn_ctrl
// Turn sequencer for a one-on-one battle. Holds both HP registers, alternates
// player and enemy strikes, drives the operand mux into the external calc_hp
// stage and commits its result into the defender's HP during HIT states.
//   clk, Reset                    : clock, synchronous active-high reset
//   start                         : (re)start a battle, any state
//   attack_btn                    : keyboard level; rising edge = player strike
//   p_atk/p_def/e_atk/e_def       : combatant stats
//   p_type/e_type                 : combatant type codes
//   hp_out, poke_faint            : result from calc_hp
//   attack_poke1, defense_poke2,
//   attackPokemon1type,
//   defensePokemon2type, hp_in    : operands to calc_hp
//   player_hp, enemy_hp           : registered HP
//   player_turn, battle_over      : state decodes
//   player_won                    : winner flag, valid while battle_over
// -----------------------------------------------------------------------------
module battle_turn_ctrl
   import battle_pkg::*;
#(
   parameter logic [HP_W-1:0] MAX_HP      = 6'd63,
   parameter int              ENEMY_DELAY = 24
)(
   input  logic              clk,
   input  logic              Reset,
   input  logic              start,
   input  logic              attack_btn,
   input  logic [STAT_W-1:0] p_atk,
   input  logic [STAT_W-1:0] p_def,
   input  logic [STAT_W-1:0] e_atk,
   input  logic [STAT_W-1:0] e_def,
   input  logic [2:0]        p_type,
   input  logic [2:0]        e_type,
   input  logic [HP_W-1:0]   hp_out,
   input  logic              poke_faint,
   output logic [STAT_W-1:0] attack_poke1,
   output logic [STAT_W-1:0] defense_poke2,
   output logic [2:0]        attackPokemon1type,
   output logic [2:0]        defensePokemon2type,
   output logic [HP_W-1:0]   hp_in,
   output logic [HP_W-1:0]   player_hp,
   output logic [HP_W-1:0]   enemy_hp,
   output logic              player_turn,
   output logic              battle_over,
   output logic              player_won
);

   localparam int CNT_W = (ENEMY_DELAY > 1) ? $clog2(ENEMY_DELAY) : 1;
   // Loading DELAY-1 and leaving on zero gives exactly DELAY wait cycles.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ENEMY_DELAY - 1);

   turn_state_t     state_q, state_d;
   logic [HP_W-1:0] player_hp_q, player_hp_d;
   logic [HP_W-1:0] enemy_hp_q, enemy_hp_d;
   logic            won_q, won_d;
   logic            btn_q;
   logic            atk_edge;
   logic            cnt_load, cnt_dec, cnt_zero;

   assign atk_edge = attack_btn & ~btn_q;

   // State and datapath registers; Reset wins, so no HP commit on a HIT cycle.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         player_hp_q <= MAX_HP;
         enemy_hp_q  <= MAX_HP;
         won_q       <= 1'b0;
         btn_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         player_hp_q <= player_hp_d;
         enemy_hp_q  <= enemy_hp_d;
         won_q       <= won_d;
         btn_q       <= attack_btn;   // tracks in every state: held button never re-fires
      end
   end

   // Next-state logic; start overrides everything, including an attack edge.
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ST_PLAYER_WAIT;
      end else begin
         unique case (state_q)
            ST_IDLE:        state_d = ST_IDLE;
            ST_PLAYER_WAIT: if (atk_edge) state_d = ST_PLAYER_HIT;
            ST_PLAYER_HIT:  state_d = poke_faint ? ST_DONE : ST_ENEMY_WAIT;
            ST_ENEMY_WAIT:  if (cnt_zero) state_d = ST_ENEMY_HIT;
            ST_ENEMY_HIT:   state_d = poke_faint ? ST_DONE : ST_PLAYER_WAIT;
            ST_DONE:        state_d = ST_DONE;
            default:        state_d = ST_IDLE;
         endcase
      end
   end

   // HP / winner commit. calc_hp results are only taken in HIT states.
   always_comb begin
      player_hp_d = player_hp_q;
      enemy_hp_d  = enemy_hp_q;
      won_d       = won_q;
      cnt_load    = 1'b0;
      if (start) begin
         player_hp_d = MAX_HP;
         enemy_hp_d  = MAX_HP;
         won_d       = 1'b0;
      end else if (state_q == ST_PLAYER_HIT) begin
         enemy_hp_d = hp_out;
         if (poke_faint)
            won_d = 1'b1;
         else
            cnt_load = 1'b1;
      end else if (state_q == ST_ENEMY_HIT) begin
         player_hp_d = hp_out;
         if (poke_faint)
            won_d = 1'b0;
      end
   end

   assign cnt_dec = (state_q == ST_ENEMY_WAIT);

   delay_counter #(
      .W (CNT_W)
   ) u_enemy_delay (
      .clk        (clk),
      .Reset      (Reset),
      .load_i     (cnt_load),
      .load_val_i (CNT_LOAD),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   // Output decode: operand mux defaults to player-attacks outside ENEMY_HIT.
   always_comb begin
      attack_poke1        = p_atk;
      defense_poke2       = e_def;
      attackPokemon1type  = p_type;
      defensePokemon2type = e_type;
      hp_in               = enemy_hp_q;
      if (state_q == ST_ENEMY_HIT) begin
         attack_poke1        = e_atk;
         defense_poke2       = p_def;
         attackPokemon1type  = e_type;
         defensePokemon2type = p_type;
         hp_in               = player_hp_q;
      end
      player_turn = (state_q == ST_PLAYER_WAIT);
      battle_over = (state_q == ST_DONE);
   end

   assign player_hp  = player_hp_q;
   assign enemy_hp   = enemy_hp_q;
   assign player_won = won_q;

endmodule

// File: tb/tb_battle_turn_ctrl.sv
module tb_battle_turn_ctrl;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic       start = 1'b0;
   logic       attack_btn = 1'b0;
   logic [3:0] p_atk = 4'd8, p_def = 4'd3, e_atk = 4'd8, e_def = 4'd3;
   logic [2:0] p_type = 3'd0, e_type = 3'd0;
   logic [5:0] hp_out_w;
   logic       faint_w;
   logic [3:0] atk_w, def_w;
   logic [2:0] at_w, dt_w;
   logic [5:0] hp_in_w, player_hp, enemy_hp;
   logic       player_turn, battle_over, player_won;

   int tests = 0;
   int errors = 0;

   // battle model state
   logic [5:0] exp_php, exp_ehp;
   logic       exp_won;
   bit         exp_done;

   always #5 clk = ~clk;

   battle_turn_ctrl #(.MAX_HP(6'd63), .ENEMY_DELAY(D)) dut (
      .clk(clk), .Reset(Reset), .start(start), .attack_btn(attack_btn),
      .p_atk(p_atk), .p_def(p_def), .e_atk(e_atk), .e_def(e_def),
      .p_type(p_type), .e_type(e_type), .hp_out(hp_out_w), .poke_faint(faint_w),
      .attack_poke1(atk_w), .defense_poke2(def_w),
      .attackPokemon1type(at_w), .defensePokemon2type(dt_w), .hp_in(hp_in_w),
      .player_hp(player_hp), .enemy_hp(enemy_hp),
      .player_turn(player_turn), .battle_over(battle_over), .player_won(player_won)
   );

   // Damage rule of the stand-in calc_hp: 3*atk - def, +4 when attacker type
   // is the "next" type after the defender's, never below 1.
   function automatic int dmg_of(logic [3:0] a, logic [3:0] d, logic [2:0] at, logic [2:0] dt);
      int x;
      x = 3 * int'(a) - int'(d);
      if (int'(at) == (int'(dt) + 1) % 8) x += 4;
      if (x < 1) x = 1;
      return x;
   endfunction

   function automatic logic [5:0] apply_hit(logic [5:0] hp, int dmg);
      return (int'(hp) > dmg) ? 6'(int'(hp) - dmg) : 6'd0;
   endfunction

   always_comb begin
      hp_out_w = apply_hit(hp_in_w, dmg_of(atk_w, def_w, at_w, dt_w));
      faint_w  = (hp_out_w == 6'd0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_battle();
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_php = 6'd63; exp_ehp = 6'd63; exp_won = 1'b0; exp_done = 1'b0;
   endtask

   // One full exchange: player strike, enemy delay, enemy strike.
   task automatic do_round(input bit hold, input int pulse_at, input bit rst_at_hit);
      tests++; if (player_turn !== 1'b1) begin errors++; $display("FAIL round_pre_turn: got %0b exp 1", player_turn); end
      attack_btn = 1'b1;
      tick();                                   // now PLAYER_HIT
      if (!hold) attack_btn = 1'b0;
      tests++; if (player_turn !== 1'b0) begin errors++; $display("FAIL phit_turn: got %0b exp 0", player_turn); end
      tests++; if (atk_w !== p_atk || def_w !== e_def || at_w !== p_type || dt_w !== e_type)
         begin errors++; $display("FAIL phit_mux: got atk=%0d def=%0d at=%0d dt=%0d exp %0d %0d %0d %0d", atk_w, def_w, at_w, dt_w, p_atk, e_def, p_type, e_type); end
      tests++; if (hp_in_w !== exp_ehp) begin errors++; $display("FAIL phit_hp_in: got %0d exp %0d", hp_in_w, exp_ehp); end
      exp_ehp = apply_hit(exp_ehp, dmg_of(p_atk, e_def, p_type, e_type));
      tick();                                   // enemy_hp committed
      tests++; if (enemy_hp !== exp_ehp) begin errors++; $display("FAIL enemy_hp: got %0d exp %0d", enemy_hp, exp_ehp); end
      if (exp_ehp == 6'd0) begin
         exp_won = 1'b1; exp_done = 1'b1;
         tests++; if (battle_over !== 1'b1 || player_won !== 1'b1) begin errors++; $display("FAIL win_done: got over=%0b won=%0b exp 1 1", battle_over, player_won); end
         $display("[TB] round: enemy fainted, player_hp=%0d enemy_hp=%0d", player_hp, enemy_hp);
         return;
      end
      for (int i = 0; i < D; i++) begin
         tests++; if (player_turn !== 1'b0 || battle_over !== 1'b0 || atk_w !== p_atk || hp_in_w !== exp_ehp)
            begin errors++; $display("FAIL ewait_%0d: got turn=%0b over=%0b atk=%0d hp_in=%0d exp 0 0 %0d %0d", i, player_turn, battle_over, atk_w, hp_in_w, p_atk, exp_ehp); end
         if (!hold && pulse_at >= 0) attack_btn = (i == pulse_at);
         tick();
      end
      if (!hold) attack_btn = 1'b0;
      // exactly D wait cycles have elapsed: must be ENEMY_HIT now
      tests++; if (atk_w !== e_atk || def_w !== p_def || at_w !== e_type || dt_w !== p_type)
         begin errors++; $display("FAIL ehit_mux: got atk=%0d def=%0d at=%0d dt=%0d exp %0d %0d %0d %0d", atk_w, def_w, at_w, dt_w, e_atk, p_def, e_type, p_type); end
      tests++; if (hp_in_w !== exp_php) begin errors++; $display("FAIL ehit_hp_in: got %0d exp %0d", hp_in_w, exp_php); end
      if (rst_at_hit) begin
         Reset = 1'b1;
         tick();
         Reset = 1'b0;
         exp_php = 6'd63; exp_ehp = 6'd63; exp_won = 1'b0; exp_done = 1'b1;
         tests++; if (player_hp !== 6'd63 || enemy_hp !== 6'd63) begin errors++; $display("FAIL rst_hit_hp: got p=%0d e=%0d exp 63 63", player_hp, enemy_hp); end
         tests++; if (battle_over !== 1'b0 || player_turn !== 1'b0 || player_won !== 1'b0) begin errors++; $display("FAIL rst_hit_flags: got over=%0b turn=%0b won=%0b exp 0 0 0", battle_over, player_turn, player_won); end
         $display("[TB] round: reset during enemy hit");
         return;
      end
      exp_php = apply_hit(exp_php, dmg_of(e_atk, p_def, e_type, p_type));
      tick();
      tests++; if (player_hp !== exp_php) begin errors++; $display("FAIL player_hp: got %0d exp %0d", player_hp, exp_php); end
      if (exp_php == 6'd0) begin
         exp_done = 1'b1;
         tests++; if (battle_over !== 1'b1 || player_won !== 1'b0) begin errors++; $display("FAIL loss_done: got over=%0b won=%0b exp 1 0", battle_over, player_won); end
      end else begin
         tests++; if (player_turn !== 1'b1) begin errors++; $display("FAIL back_to_player: got %0b exp 1", player_turn); end
      end
      $display("[TB] round: player_hp=%0d enemy_hp=%0d", player_hp, enemy_hp);
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick(); tick();
      Reset = 1'b0;
      tests++; if (player_hp !== 6'd63 || enemy_hp !== 6'd63) begin errors++; $display("FAIL reset_hp: got p=%0d e=%0d exp 63 63", player_hp, enemy_hp); end
      tests++; if (player_turn !== 1'b0 || battle_over !== 1'b0 || player_won !== 1'b0) begin errors++; $display("FAIL reset_flags: got turn=%0b over=%0b won=%0b exp 0 0 0", player_turn, battle_over, player_won); end
      tests++; if (atk_w !== p_atk || def_w !== e_def || hp_in_w !== 6'd63) begin errors++; $display("FAIL reset_mux: got atk=%0d def=%0d hp_in=%0d exp %0d %0d 63", atk_w, def_w, hp_in_w, p_atk, e_def); end
      // IDLE ignores attack edges
      attack_btn = 1'b1; tick(); attack_btn = 1'b0; tick();
      tests++; if (player_turn !== 1'b0 || enemy_hp !== 6'd63) begin errors++; $display("FAIL idle_ignore: got turn=%0b ehp=%0d exp 0 63", player_turn, enemy_hp); end
      $display("[TB] reset checked");
   endtask

   task automatic test_start();
      start_battle();
      tests++; if (player_turn !== 1'b1) begin errors++; $display("FAIL start_turn: got %0b exp 1", player_turn); end
      tests++; if (player_hp !== 6'd63 || enemy_hp !== 6'd63) begin errors++; $display("FAIL start_hp: got p=%0d e=%0d exp 63 63", player_hp, enemy_hp); end
      $display("[TB] start checked");
   endtask

   task automatic test_full_battle();
      p_atk = 4'd8; e_def = 4'd3; e_atk = 4'd8; p_def = 4'd3; p_type = 3'd0; e_type = 3'd0;
      start_battle();
      for (int r = 0; r < 3; r++) do_round(1'b0, -1, 1'b0);
      tests++; if (enemy_hp !== 6'd0 || player_hp !== 6'd21) begin errors++; $display("FAIL plan_final_hp: got p=%0d e=%0d exp 21 0", player_hp, enemy_hp); end
      for (int k = 0; k < 3; k++) tick();
      tests++; if (battle_over !== 1'b1 || player_won !== 1'b1 || enemy_hp !== 6'd0) begin errors++; $display("FAIL done_hold: got over=%0b won=%0b ehp=%0d exp 1 1 0", battle_over, player_won, enemy_hp); end
   endtask

   task automatic test_start_in_done();
      start = 1'b1; attack_btn = 1'b1;
      tick();
      start = 1'b0;
      tests++; if (player_turn !== 1'b1 || battle_over !== 1'b0 || player_won !== 1'b0) begin errors++; $display("FAIL restart_flags: got turn=%0b over=%0b won=%0b exp 1 0 0", player_turn, battle_over, player_won); end
      tests++; if (player_hp !== 6'd63 || enemy_hp !== 6'd63) begin errors++; $display("FAIL restart_hp: got p=%0d e=%0d exp 63 63", player_hp, enemy_hp); end
      tick(); tick();
      tests++; if (player_turn !== 1'b1 || enemy_hp !== 6'd63) begin errors++; $display("FAIL restart_no_hit: got turn=%0b ehp=%0d exp 1 63", player_turn, enemy_hp); end
      attack_btn = 1'b0; tick();
      $display("[TB] start+attack in DONE checked");
   endtask

   task automatic test_hold();
      start_battle();
      do_round(1'b1, -1, 1'b0);                 // button stays high throughout
      for (int k = 0; k < 5; k++) tick();
      tests++; if (player_turn !== 1'b1 || enemy_hp !== 6'd42) begin errors++; $display("FAIL hold_no_refire: got turn=%0b ehp=%0d exp 1 42", player_turn, enemy_hp); end
      attack_btn = 1'b0; tick();
      do_round(1'b0, -1, 1'b0);
      tests++; if (enemy_hp !== 6'd21) begin errors++; $display("FAIL hold_second_hit: got %0d exp 21", enemy_hp); end
   endtask

   task automatic test_ignore_pulse();
      start_battle();
      do_round(1'b0, 1, 1'b0);
      for (int k = 0; k < 3; k++) tick();
      tests++; if (player_turn !== 1'b1 || enemy_hp !== 6'd42) begin errors++; $display("FAIL pulse_not_queued: got turn=%0b ehp=%0d exp 1 42", player_turn, enemy_hp); end
      do_round(1'b0, D - 1, 1'b0);
      tick();
      tests++; if (player_turn !== 1'b1 || enemy_hp !== 6'd21) begin errors++; $display("FAIL pulse_last_wait: got turn=%0b ehp=%0d exp 1 21", player_turn, enemy_hp); end
   endtask

   task automatic test_reset_mid();
      p_atk = 4'd2;                             // 3 damage to the enemy per hit
      start_battle();
      do_round(1'b0, -1, 1'b0);
      do_round(1'b0, -1, 1'b0);
      tests++; if (player_hp !== 6'd21) begin errors++; $display("FAIL pre_reset_php: got %0d exp 21", player_hp); end
      do_round(1'b0, -1, 1'b1);
      attack_btn = 1'b1; tick(); attack_btn = 1'b0; tick();
      tests++; if (player_turn !== 1'b0 || enemy_hp !== 6'd63 || player_hp !== 6'd63) begin errors++; $display("FAIL post_reset_idle: got turn=%0b p=%0d e=%0d exp 0 63 63", player_turn, player_hp, enemy_hp); end
   endtask

   task automatic test_random();
      int n;
      for (int b = 0; b < 6; b++) begin
         p_atk = 4'($urandom_range(15, 0)); p_def = 4'($urandom_range(15, 0));
         e_atk = 4'($urandom_range(15, 0)); e_def = 4'($urandom_range(15, 0));
         p_type = 3'($urandom_range(7, 0)); e_type = 3'($urandom_range(7, 0));
         start_battle();
         for (int r = 0; r < 15 && !exp_done; r++) begin
            n = $urandom_range(3, 0);
            for (int k = 0; k < n; k++) begin
               tick();
               tests++; if (player_turn !== 1'b1 || enemy_hp !== exp_ehp || player_hp !== exp_php)
                  begin errors++; $display("FAIL rand_idle: got turn=%0b p=%0d e=%0d exp 1 %0d %0d", player_turn, player_hp, enemy_hp, exp_php, exp_ehp); end
            end
            do_round(1'b0, int'($urandom_range(D, 0)) - 1, 1'b0);
         end
         if (exp_done) begin
            tests++; if (player_won !== exp_won) begin errors++; $display("FAIL rand_winner: got %0b exp %0b", player_won, exp_won); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_full_battle();
      test_start_in_done();
      test_hold();
      test_ignore_pulse();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
